// File: rtl/gray_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gray_mon_pkg
//  Description : Shared encodings for the Gray counter monitor. These are the
//                FSM state codes and the step classification of one sample
//                against the previous one.
//                Optional macro GRAY_MON_DOWN_EN adds the DEC and UNDER
//                step classes.
//  Revision    : 1.0 - initial release
// ============================================================================
package gray_mon_pkg;

    // FSM state encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_ERROR = 2'd2;

    // Step classification of a new sample relative to the reference sample
    localparam logic [2:0] HOLD    = 3'd0;
    localparam logic [2:0] ADV     = 3'd1;
    localparam logic [2:0] WRAP    = 3'd2;
    localparam logic [2:0] ILLEGAL = 3'd3;
`ifdef GRAY_MON_DOWN_EN
    localparam logic [2:0] DEC     = 3'd4;
    localparam logic [2:0] UNDER   = 3'd5;
`endif

endpackage
`default_nettype wire

// File: rtl/gray2bin.sv
`default_nettype none
// ============================================================================
//  Module      : gray2bin
//  Description : Purely combinational Gray-to-binary decoder. Each binary bit
//                is the XOR of its own Gray bit and every Gray bit above it.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray2bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // Each bit is computed as an independent reduction, which avoids a
    // self-referencing ripple chain.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[WIDTH-1:i];
    end

endmodule
`default_nettype wire

// File: rtl/gray_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : gray_monitor
//  Description : Samples an upstream Gray counter on Valid. It checks every
//                step for a legal single-bit advance and extends the count
//                into a wide running total plus a wrap counter. Illegal
//                steps are flagged with a one-cycle pulse and a sticky flag.
//                Optional macro GRAY_MON_DOWN_EN also accepts decrements
//                and underflows as legal steps.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_monitor #(
    parameter int WIDTH  = 3,
    parameter int CNT_W  = 16,
    parameter int WRAP_W = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Valid,
    input  logic [WIDTH-1:0]  Gray,
    input  logic              Clear,
    output logic [WIDTH-1:0]  Binary,
    output logic [CNT_W-1:0]  Total,
    output logic [WRAP_W-1:0] Wraps,
    output logic              Locked,
    output logic              Step_err,
    output logic              Err_sticky
);

    import gray_mon_pkg::*;

    localparam logic [WIDTH-1:0] c_max  = '1;
    localparam logic [WIDTH-1:0] c_zero = '0;

    logic [1:0]        r_state;
    logic [WIDTH-1:0]  r_prev;
    logic [WIDTH-1:0]  r_binary;
    logic [CNT_W-1:0]  r_total;
    logic [WRAP_W-1:0] r_wraps;
    logic              r_locked;
    logic              r_step_err;
    logic              r_err_sticky;

    logic [WIDTH-1:0]  w_b;
    logic [WIDTH-1:0]  w_p;
    logic [2:0]        w_step;

    gray2bin #(.WIDTH(WIDTH)) u_dec_gray (
        .i_gray (Gray),
        .o_bin  (w_b)
    );

    gray2bin #(.WIDTH(WIDTH)) u_dec_prev (
        .i_gray (r_prev),
        .o_bin  (w_p)
    );

    // Classify the incoming sample against the reference sample
    always_comb begin
        w_step = ILLEGAL;
        if (Gray == r_prev) begin
            w_step = HOLD;
        end else if ((w_p != c_max) && (w_b == w_p + 1'b1)) begin
            w_step = ADV;
        end else if ((w_p == c_max) && (w_b == c_zero)) begin
            w_step = WRAP;
`ifdef GRAY_MON_DOWN_EN
        end else if ((w_p != c_zero) && (w_b == w_p - 1'b1)) begin
            w_step = DEC;
        end else if ((w_p == c_zero) && (w_b == c_max)) begin
            w_step = UNDER;
`endif
        end
    end

    // Tracking FSM with all outputs registered; Clear acts as a synchronous reset
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= S_IDLE;
            r_prev       <= '0;
            r_binary     <= '0;
            r_total      <= '0;
            r_wraps      <= '0;
            r_locked     <= 1'b0;
            r_step_err   <= 1'b0;
            r_err_sticky <= 1'b0;
        end else if (Clear) begin
            r_state      <= S_IDLE;
            r_prev       <= '0;
            r_binary     <= '0;
            r_total      <= '0;
            r_wraps      <= '0;
            r_locked     <= 1'b0;
            r_step_err   <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_step_err <= 1'b0;
            if (Valid) begin
                case (r_state)
                    S_IDLE: begin
                        // First sample only establishes the reference
                        r_prev   <= Gray;
                        r_binary <= w_b;
                        r_total  <= {{(CNT_W-WIDTH){1'b0}}, w_b};
                        r_state  <= S_TRACK;
                        r_locked <= 1'b1;
                    end
                    S_TRACK: begin
                        case (w_step)
                            HOLD: begin
                            end
                            ADV: begin
                                r_prev   <= Gray;
                                r_binary <= w_b;
                                r_total  <= r_total + 1'b1;
                            end
                            WRAP: begin
                                r_prev   <= Gray;
                                r_binary <= w_b;
                                r_total  <= r_total + 1'b1;
                                r_wraps  <= r_wraps + 1'b1;
                            end
`ifdef GRAY_MON_DOWN_EN
                            DEC: begin
                                r_prev   <= Gray;
                                r_binary <= w_b;
                                r_total  <= r_total - 1'b1;
                            end
                            UNDER: begin
                                r_prev   <= Gray;
                                r_binary <= w_b;
                                r_total  <= r_total - 1'b1;
                                r_wraps  <= r_wraps - 1'b1;
                            end
`endif
                            default: begin
                                // Counts hold; the new code becomes the resync reference
                                r_prev       <= Gray;
                                r_step_err   <= 1'b1;
                                r_err_sticky <= 1'b1;
                                r_state      <= S_ERROR;
                                r_locked     <= 1'b0;
                            end
                        endcase
                    end
                    S_ERROR: begin
                        // Resync without checking; counts are not touched
                        r_prev   <= Gray;
                        r_binary <= w_b;
                        r_state  <= S_TRACK;
                        r_locked <= 1'b1;
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Binary     = r_binary;
    assign Total      = r_total;
    assign Wraps      = r_wraps;
    assign Locked     = r_locked;
    assign Step_err   = r_step_err;
    assign Err_sticky = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_gray_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_monitor
//  Description : Directed self-checking bench for gray_monitor. A default
//                instance and a narrow instance (CNT_W=4) share the stimulus.
//                Expectations for the down-step case follow GRAY_MON_DOWN_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_monitor;

    logic        Clk     = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Valid   = 1'b0;
    logic        Clear   = 1'b0;
    logic [2:0]  Gray    = 3'b000;

    logic [2:0]  Binary;
    logic [15:0] Total;
    logic [7:0]  Wraps;
    logic        Locked;
    logic        Step_err;
    logic        Err_sticky;

    logic [2:0]  n_Binary;
    logic [3:0]  n_Total;
    logic [7:0]  n_Wraps;
    logic        n_Locked;
    logic        n_Step_err;
    logic        n_Err_sticky;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] gseq [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                             3'b110, 3'b111, 3'b101, 3'b100};

    always #5 Clk = ~Clk;

    gray_monitor #(.WIDTH(3), .CNT_W(16), .WRAP_W(8)) u_dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Valid      (Valid),
        .Gray       (Gray),
        .Clear      (Clear),
        .Binary     (Binary),
        .Total      (Total),
        .Wraps      (Wraps),
        .Locked     (Locked),
        .Step_err   (Step_err),
        .Err_sticky (Err_sticky)
    );

    gray_monitor #(.WIDTH(3), .CNT_W(4), .WRAP_W(8)) u_dut_n (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Valid      (Valid),
        .Gray       (Gray),
        .Clear      (Clear),
        .Binary     (n_Binary),
        .Total      (n_Total),
        .Wraps      (n_Wraps),
        .Locked     (n_Locked),
        .Step_err   (n_Step_err),
        .Err_sticky (n_Err_sticky)
    );

    // Apply one cycle of stimulus at the falling edge, then settle past the rising edge
    task automatic drive(input logic v, input logic [2:0] g, input logic c);
        @(negedge Clk);
        Valid = v;
        Gray  = g;
        Clear = c;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++; if (Binary !== 3'd0)     begin n_errors++; $display("FAIL rst_binary: got %0d expected 0", Binary); end
        n_checks++; if (Total !== 16'd0)     begin n_errors++; $display("FAIL rst_total: got %0d expected 0", Total); end
        n_checks++; if (Wraps !== 8'd0)      begin n_errors++; $display("FAIL rst_wraps: got %0d expected 0", Wraps); end
        n_checks++; if (Locked !== 1'b0)     begin n_errors++; $display("FAIL rst_locked: got %b expected 0", Locked); end
        n_checks++; if (Step_err !== 1'b0)   begin n_errors++; $display("FAIL rst_step_err: got %b expected 0", Step_err); end
        n_checks++; if (Err_sticky !== 1'b0) begin n_errors++; $display("FAIL rst_sticky: got %b expected 0", Err_sticky); end
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // 16 samples from 000: first sample seeds Total=0, 15 advances, one wrap
    task automatic test_count_sequence;
        drive(1'b1, gseq[0], 1'b0);
        n_checks++; if (Locked !== 1'b1) begin n_errors++; $display("FAIL seq_locked_first: got %b expected 1", Locked); end
        n_checks++; if (Total !== 16'd0) begin n_errors++; $display("FAIL seq_total_first: got %0d expected 0", Total); end
        for (int i = 1; i < 16; i++) drive(1'b1, gseq[i % 8], 1'b0);
        n_checks++; if (Total !== 16'd15)    begin n_errors++; $display("FAIL seq_total: got %0d expected 15", Total); end
        n_checks++; if (Wraps !== 8'd1)      begin n_errors++; $display("FAIL seq_wraps: got %0d expected 1", Wraps); end
        n_checks++; if (Binary !== 3'b111)   begin n_errors++; $display("FAIL seq_binary: got %b expected 111", Binary); end
        n_checks++; if (Err_sticky !== 1'b0) begin n_errors++; $display("FAIL seq_sticky: got %b expected 0", Err_sticky); end
    endtask

    // From prev=011 (bin 2), 110 (bin 4) is illegal; 111 then resyncs
    task automatic test_illegal;
        drive(1'b1, 3'b000, 1'b0);   // wrap: Total 16, Wraps 2
        drive(1'b1, 3'b001, 1'b0);   // Total 17
        drive(1'b1, 3'b011, 1'b0);   // Total 18
        drive(1'b1, 3'b110, 1'b0);
        n_checks++; if (Step_err !== 1'b1)   begin n_errors++; $display("FAIL ill_step_err: got %b expected 1", Step_err); end
        n_checks++; if (Err_sticky !== 1'b1) begin n_errors++; $display("FAIL ill_sticky: got %b expected 1", Err_sticky); end
        n_checks++; if (Total !== 16'd18)    begin n_errors++; $display("FAIL ill_total: got %0d expected 18", Total); end
        n_checks++; if (Binary !== 3'd2)     begin n_errors++; $display("FAIL ill_binary_hold: got %0d expected 2", Binary); end
        n_checks++; if (Locked !== 1'b0)     begin n_errors++; $display("FAIL ill_locked: got %b expected 0", Locked); end
        drive(1'b0, 3'b110, 1'b0);
        n_checks++; if (Step_err !== 1'b0)   begin n_errors++; $display("FAIL ill_pulse_width: got %b expected 0", Step_err); end
        drive(1'b1, 3'b111, 1'b0);
        n_checks++; if (Locked !== 1'b1)     begin n_errors++; $display("FAIL resync_locked: got %b expected 1", Locked); end
        n_checks++; if (Binary !== 3'b101)   begin n_errors++; $display("FAIL resync_binary: got %b expected 101", Binary); end
        n_checks++; if (Total !== 16'd18)    begin n_errors++; $display("FAIL resync_total: got %0d expected 18", Total); end
        n_checks++; if (Err_sticky !== 1'b1) begin n_errors++; $display("FAIL resync_sticky: got %b expected 1", Err_sticky); end
    endtask

    // Valid low, then a repeated code: nothing moves; then one advance
    task automatic test_stall;
        for (int i = 0; i < 5; i++) drive(1'b0, 3'b010, 1'b0);
        n_checks++; if (Total !== 16'd18)  begin n_errors++; $display("FAIL stall_total: got %0d expected 18", Total); end
        n_checks++; if (Binary !== 3'd5)   begin n_errors++; $display("FAIL stall_binary: got %0d expected 5", Binary); end
        drive(1'b1, 3'b111, 1'b0);
        n_checks++; if (Total !== 16'd18)  begin n_errors++; $display("FAIL repeat_total: got %0d expected 18", Total); end
        n_checks++; if (Step_err !== 1'b0) begin n_errors++; $display("FAIL repeat_step_err: got %b expected 0", Step_err); end
        drive(1'b1, 3'b101, 1'b0);
        n_checks++; if (Total !== 16'd19)  begin n_errors++; $display("FAIL post_stall_total: got %0d expected 19", Total); end
    endtask

    // Clear with Valid: Clear wins, FSM back to idle (next sample just seeds)
    task automatic test_clear_priority;
        drive(1'b1, 3'b001, 1'b1);
        n_checks++; if (Err_sticky !== 1'b0) begin n_errors++; $display("FAIL clr_sticky: got %b expected 0", Err_sticky); end
        n_checks++; if (Total !== 16'd0)     begin n_errors++; $display("FAIL clr_total: got %0d expected 0", Total); end
        n_checks++; if (Wraps !== 8'd0)      begin n_errors++; $display("FAIL clr_wraps: got %0d expected 0", Wraps); end
        n_checks++; if (Locked !== 1'b0)     begin n_errors++; $display("FAIL clr_locked: got %b expected 0", Locked); end
        n_checks++; if (Binary !== 3'd0)     begin n_errors++; $display("FAIL clr_binary: got %0d expected 0", Binary); end
        drive(1'b1, 3'b110, 1'b0);
        n_checks++; if (Total !== 16'd4)     begin n_errors++; $display("FAIL clr_idle_total: got %0d expected 4", Total); end
        n_checks++; if (Step_err !== 1'b0)   begin n_errors++; $display("FAIL clr_idle_step_err: got %b expected 0", Step_err); end
        n_checks++; if (Locked !== 1'b1)     begin n_errors++; $display("FAIL clr_idle_locked: got %b expected 1", Locked); end
    endtask

    // Asynchronous reset between edges while Total=9
    task automatic test_async_reset;
        drive(1'b0, 3'b000, 1'b1);
        for (int i = 0; i < 10; i++) drive(1'b1, gseq[i % 8], 1'b0);
        n_checks++; if (Total !== 16'd9) begin n_errors++; $display("FAIL areset_pre_total: got %0d expected 9", Total); end
        n_checks++; if (Wraps !== 8'd1)  begin n_errors++; $display("FAIL areset_pre_wraps: got %0d expected 1", Wraps); end
        @(negedge Clk);
        Valid = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        n_checks++; if (Total !== 16'd0) begin n_errors++; $display("FAIL areset_total: got %0d expected 0", Total); end
        n_checks++; if (Wraps !== 8'd0)  begin n_errors++; $display("FAIL areset_wraps: got %0d expected 0", Wraps); end
        n_checks++; if (Binary !== 3'd0) begin n_errors++; $display("FAIL areset_binary: got %0d expected 0", Binary); end
        n_checks++; if (Locked !== 1'b0) begin n_errors++; $display("FAIL areset_locked: got %b expected 0", Locked); end
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // 20 advances: narrow Total wraps silently to 4, two code wraps
    task automatic test_narrow_total;
        drive(1'b0, 3'b000, 1'b1);
        for (int i = 0; i < 21; i++) drive(1'b1, gseq[i % 8], 1'b0);
        n_checks++; if (n_Total !== 4'd4)      begin n_errors++; $display("FAIL narrow_total: got %0d expected 4", n_Total); end
        n_checks++; if (n_Wraps !== 8'd2)      begin n_errors++; $display("FAIL narrow_wraps: got %0d expected 2", n_Wraps); end
        n_checks++; if (n_Err_sticky !== 1'b0) begin n_errors++; $display("FAIL narrow_sticky: got %b expected 0", n_Err_sticky); end
        n_checks++; if (Total !== 16'd20)      begin n_errors++; $display("FAIL wide_total20: got %0d expected 20", Total); end
        n_checks++; if (Binary !== 3'd4)       begin n_errors++; $display("FAIL wide_binary20: got %0d expected 4", Binary); end
    endtask

    // prev=000 then 100, then 101: underflow and decrement, or illegal + resync
    task automatic test_down_step;
        drive(1'b0, 3'b000, 1'b1);
        drive(1'b1, 3'b000, 1'b0);
        drive(1'b1, 3'b100, 1'b0);
`ifdef GRAY_MON_DOWN_EN
        n_checks++; if (Step_err !== 1'b0)    begin n_errors++; $display("FAIL under_step_err: got %b expected 0", Step_err); end
        n_checks++; if (Total !== 16'hFFFF)   begin n_errors++; $display("FAIL under_total: got %h expected ffff", Total); end
        n_checks++; if (Wraps !== 8'hFF)      begin n_errors++; $display("FAIL under_wraps: got %h expected ff", Wraps); end
        n_checks++; if (n_Total !== 4'hF)     begin n_errors++; $display("FAIL under_narrow_total: got %h expected f", n_Total); end
        n_checks++; if (Binary !== 3'd7)      begin n_errors++; $display("FAIL under_binary: got %0d expected 7", Binary); end
        drive(1'b1, 3'b101, 1'b0);
        n_checks++; if (Total !== 16'hFFFE)   begin n_errors++; $display("FAIL dec_total: got %h expected fffe", Total); end
        n_checks++; if (Wraps !== 8'hFF)      begin n_errors++; $display("FAIL dec_wraps: got %h expected ff", Wraps); end
        n_checks++; if (Binary !== 3'd6)      begin n_errors++; $display("FAIL dec_binary: got %0d expected 6", Binary); end
        n_checks++; if (Err_sticky !== 1'b0)  begin n_errors++; $display("FAIL dec_sticky: got %b expected 0", Err_sticky); end
`else
        n_checks++; if (Step_err !== 1'b1)    begin n_errors++; $display("FAIL under_step_err: got %b expected 1", Step_err); end
        n_checks++; if (Total !== 16'd0)      begin n_errors++; $display("FAIL under_total: got %0d expected 0", Total); end
        n_checks++; if (Wraps !== 8'd0)       begin n_errors++; $display("FAIL under_wraps: got %0d expected 0", Wraps); end
        n_checks++; if (Err_sticky !== 1'b1)  begin n_errors++; $display("FAIL under_sticky: got %b expected 1", Err_sticky); end
        drive(1'b1, 3'b101, 1'b0);
        n_checks++; if (Binary !== 3'd6)      begin n_errors++; $display("FAIL down_resync_binary: got %0d expected 6", Binary); end
        n_checks++; if (Total !== 16'd0)      begin n_errors++; $display("FAIL down_resync_total: got %0d expected 0", Total); end
        n_checks++; if (Locked !== 1'b1)      begin n_errors++; $display("FAIL down_resync_locked: got %b expected 1", Locked); end
        n_checks++; if (Step_err !== 1'b0)    begin n_errors++; $display("FAIL down_resync_step_err: got %b expected 0", Step_err); end
`endif
    endtask

    initial begin
        test_reset();
        test_count_sequence();
        test_illegal();
        test_stall();
        test_clear_priority();
        test_async_reset();
        test_narrow_total();
        test_down_step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
